data_cache_stage4: RTL and testbench

//  Stage-4 (memory access) data cache of the 5-stage RV32I pipeline. It takes the ALU result from the EX/MEM

---
 rtl/data_cache_stage4_pkg.sv | 22 ++
 rtl/data_cache_stage4_if.sv | 22 ++
 rtl/data_cache_stage4_load_align.sv | 56 +++++
 rtl/data_cache_stage4.sv | 136 +++++++++++++
 tb/tb_data_cache_stage4.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/data_cache_stage4_pkg.sv
// Shared types and constants for the stage-4 data cache: FSM states,
// RV32I load/store size encodings and block geometry.
package data_cache_stage4_pkg;

    localparam int MEM_ADDR_W = 28;
    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        UPDATE    = 2'd3
    } dc_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/data_cache_stage4_if.sv
// Block-memory handshake between the data cache (master) and data memory (slave).
interface data_cache_stage4_if;
    import data_cache_stage4_pkg::*;

    logic                  mem_Read;
    logic                  mem_Write;
    logic [MEM_ADDR_W-1:0] mem_Address;
    logic [BLOCK_W-1:0]    mem_Writedata;
    logic [BLOCK_W-1:0]    mem_Readdata;
    logic                  mem_BusyWait;

    modport master (
        output mem_Read, mem_Write, mem_Address, mem_Writedata,
        input  mem_Readdata, mem_BusyWait
    );

    modport slave (
        input  mem_Read, mem_Write, mem_Address, mem_Writedata,
        output mem_Readdata, mem_BusyWait
    );

endinterface

// File: rtl/data_cache_stage4_load_align.sv
// Byte/half selection with sign/zero extension for loads, and the matching
// byte-lane merge of store data into the addressed word.
module data_cache_stage4_load_align
    import data_cache_stage4_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] store_data_i,
    output logic [31:0] load_data_o,
    output logic [31:0] merged_word_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [3:0]  mask_s;
    logic [31:0] rep_s;

    // Load extraction; half-word offset uses addr[1] only, so misaligned halves snap down.
    always_comb begin
        byte_s      = word_i[{byte_off_i, 3'b000} +: 8];
        half_s      = byte_off_i[1] ? word_i[31:16] : word_i[15:0];
        load_data_o = word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{byte_s[7]}}, byte_s};
            F3_H:    load_data_o = {{16{half_s[15]}}, half_s};
            F3_W:    load_data_o = word_i;
            F3_BU:   load_data_o = {24'h000000, byte_s};
            F3_HU:   load_data_o = {16'h0000, half_s};
            default: load_data_o = word_i;
        endcase
    end

    // Store lane mask and replicated data; unselected lanes keep the old word.
    always_comb begin
        mask_s = 4'b1111;
        rep_s  = store_data_i;
        case (funct3_i)
            F3_B: begin
                mask_s = 4'b0001 << byte_off_i;
                rep_s  = {4{store_data_i[7:0]}};
            end
            F3_H: begin
                mask_s = byte_off_i[1] ? 4'b1100 : 4'b0011;
                rep_s  = {2{store_data_i[15:0]}};
            end
            default: begin
                mask_s = 4'b1111;
                rep_s  = store_data_i;
            end
        endcase
        merged_word_o = (rep_s & {{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}})
                      | (word_i & ~{{8{mask_s[3]}}, {8{mask_s[2]}}, {8{mask_s[1]}}, {8{mask_s[0]}}});
    end

endmodule

// File: rtl/data_cache_stage4.sv
// Direct-mapped, write-back data cache for the memory stage: 0-cycle hits,
// miss handling via WRITEBACK/FETCH/UPDATE on a 128-bit block interface.
module data_cache_stage4
    import data_cache_stage4_pkg::*;
#(
    parameter int SETS = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          address_i,
    input  logic [31:0]          writedata_i,
    input  logic                 memRead_i,
    input  logic                 memWrite_i,
    input  logic [2:0]           funct3_i,
    output logic [31:0]          readdata_o,
    output logic                 busywait_o,
    data_cache_stage4_if.master  mem
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = MEM_ADDR_W - IDX_W;

    logic [BLOCK_W-1:0] data_q [SETS];
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [BLOCK_W-1:0] fill_q;
    dc_state_e          state_q, state_d;

    logic [IDX_W-1:0]      idx_s;
    logic [TAG_W-1:0]      atag_s;
    logic [1:0]            wsel_s;
    logic [BLOCK_W-1:0]    line_s, line_wr_s;
    logic [31:0]           word_s, load_data_s, merged_s;
    logic                  req_s, hit_s, store_hit_s, load_hit_s;
    logic                  mem_read_s, mem_write_s;
    logic [MEM_ADDR_W-1:0] mem_addr_s;
    logic [BLOCK_W-1:0]    mem_wdata_s;

    assign idx_s       = address_i[IDX_W+3:4];
    assign atag_s      = address_i[31:IDX_W+4];
    assign wsel_s      = address_i[3:2];
    assign line_s      = data_q[idx_s];
    assign word_s      = line_s[{wsel_s, 5'b00000} +: 32];
    assign req_s       = memRead_i | memWrite_i;
    assign hit_s       = (state_q == IDLE) & valid_q[idx_s] & (tag_q[idx_s] == atag_s);
    // Read+write together is handled as a store.
    assign store_hit_s = hit_s & memWrite_i;
    assign load_hit_s  = hit_s & memRead_i & ~memWrite_i;

    // Outputs are forced low while reset is held, even with a request pending.
    assign readdata_o  = (RESET & load_hit_s) ? load_data_s : 32'h0000_0000;
    assign busywait_o  = RESET & ((state_q != IDLE) | (req_s & ~hit_s));

    assign mem.mem_Read      = mem_read_s;
    assign mem.mem_Write     = mem_write_s;
    assign mem.mem_Address   = mem_addr_s;
    assign mem.mem_Writedata = mem_wdata_s;

    data_cache_stage4_load_align u_align (
        .word_i        (word_s),
        .byte_off_i    (address_i[1:0]),
        .funct3_i      (funct3_i),
        .store_data_i  (writedata_i),
        .load_data_o   (load_data_s),
        .merged_word_o (merged_s)
    );

    // Line image with the store word merged in.
    always_comb begin
        line_wr_s = line_s;
        line_wr_s[{wsel_s, 5'b00000} +: 32] = merged_s;
    end

    // Miss FSM next state and memory request outputs.
    always_comb begin
        state_d     = state_q;
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        mem_addr_s  = {MEM_ADDR_W{1'b0}};
        mem_wdata_s = {BLOCK_W{1'b0}};
        case (state_q)
            IDLE: begin
                if (req_s && !hit_s) begin
                    state_d = (valid_q[idx_s] && dirty_q[idx_s]) ? WRITEBACK : FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            WRITEBACK: begin
                mem_write_s = 1'b1;
                mem_addr_s  = {tag_q[idx_s], idx_s};
                mem_wdata_s = line_s;
                state_d     = mem.mem_BusyWait ? WRITEBACK : FETCH;
            end
            FETCH: begin
                mem_read_s = 1'b1;
                mem_addr_s = {atag_s, idx_s};
                state_d    = mem.mem_BusyWait ? FETCH : UPDATE;
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state and per-line status; an asserted reset abandons any transfer.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            valid_q <= {SETS{1'b0}};
            dirty_q <= {SETS{1'b0}};
        end else begin
            state_q <= state_d;
            if (state_q == UPDATE) begin
                valid_q[idx_s] <= 1'b1;
                dirty_q[idx_s] <= 1'b0;
            end else if (store_hit_s) begin
                dirty_q[idx_s] <= 1'b1;
            end
        end
    end

    // Data/tag arrays and refill buffer carry no reset; valid bits guard them.
    always_ff @(posedge CLK) begin
        if (state_q == FETCH && !mem.mem_BusyWait) begin
            fill_q <= mem.mem_Readdata;
        end
        if (state_q == UPDATE) begin
            data_q[idx_s] <= fill_q;
            tag_q[idx_s]  <= atag_s;
        end else if (store_hit_s) begin
            data_q[idx_s] <= line_wr_s;
        end
    end

endmodule

// File: tb/tb_data_cache_stage4.sv
// Directed bench for data_cache_stage4: hit vectors from a table plus
// hand-written miss, dirty-eviction and reset-abort sequences.
module tb_data_cache_stage4;
    import data_cache_stage4_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] address, writedata, readdata;
    logic        memRead, memWrite, busywait;
    logic [2:0]  funct3;

    int n_pass = 0;
    int n_tot  = 0;

    data_cache_stage4_if mif();

    data_cache_stage4 #(.SETS(8)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .address_i   (address),
        .writedata_i (writedata),
        .memRead_i   (memRead),
        .memWrite_i  (memWrite),
        .funct3_i    (funct3),
        .readdata_o  (readdata),
        .busywait_o  (busywait),
        .mem         (mif)
    );

    always #5 CLK = ~CLK;

    // Memory model: each request takes 3 cycles, busy on the first two.
    logic [1:0]   mcnt = 2'd0;
    logic [127:0] mem_wr [64];
    bit   [63:0]  mem_wv;

    function automatic logic [127:0] blk(input logic [5:0] b);
        blk = {16'hA000, 2'b00, b, 8'h03, 16'hA000, 2'b00, b, 8'h02,
               16'hA000, 2'b00, b, 8'h01, 16'hA000, 2'b00, b, 8'h00};
    endfunction

    assign mif.mem_BusyWait = (mif.mem_Read | mif.mem_Write) & (mcnt != 2'd2);
    assign mif.mem_Readdata = !mif.mem_Read ? 128'h0 :
                              mem_wv[mif.mem_Address[5:0]] ? mem_wr[mif.mem_Address[5:0]] :
                              blk(mif.mem_Address[5:0]);

    always @(posedge CLK) begin
        if (mif.mem_Read | mif.mem_Write) mcnt <= (mcnt == 2'd2) ? 2'd0 : mcnt + 2'd1;
        else                              mcnt <= 2'd0;
        if (mif.mem_Write && !mif.mem_BusyWait) begin
            mem_wr[mif.mem_Address[5:0]] <= mif.mem_Writedata;
            mem_wv[mif.mem_Address[5:0]] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else             n_pass++;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        memRead = rd; memWrite = wr; funct3 = f3; address = a; writedata = wd;
    endtask

    // Follows a miss until busywait drops, recording the memory traffic seen.
    task automatic wait_miss(output int n, output bit saw_wb, output logic [27:0] wba,
                             output logic [127:0] wbd, output logic [27:0] rda, output bit ov);
        n = 0; saw_wb = 1'b0; wba = 28'h0; wbd = 128'h0; rda = 28'h0; ov = 1'b0;
        while (busywait === 1'b1 && n < 60) begin
            if (mif.mem_Write) begin saw_wb = 1'b1; wba = mif.mem_Address; wbd = mif.mem_Writedata; end
            if (mif.mem_Read)  rda = mif.mem_Address;
            if (mif.mem_Read && mif.mem_Write) ov = 1'b1;
            n++;
            @(negedge CLK); #2;
        end
        chk("miss_within_bound", 128'(n < 60), 128'h1);
    endtask

    typedef struct {
        string       nm;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_busy;
    } vec_t;

    vec_t          vq[$];
    int            n;
    bit            saw_wb, ov;
    logic [27:0]   wba, rda;
    logic [127:0]  wbd;
    logic [127:0]  exp_blk1;

    initial begin
        // Hits on line idx1/tag0, resident after the first cold miss.
        vq.push_back('{"sw_14",       1'b0, 1'b1, F3_W,  32'h14, 32'hDEADBEEF, 32'h0,        1'b0});
        vq.push_back('{"lb_17",       1'b1, 1'b0, F3_B,  32'h17, 32'h0,        32'hFFFFFFDE, 1'b0});
        vq.push_back('{"lbu_17",      1'b1, 1'b0, F3_BU, 32'h17, 32'h0,        32'h000000DE, 1'b0});
        vq.push_back('{"lw_14",       1'b1, 1'b0, F3_W,  32'h14, 32'h0,        32'hDEADBEEF, 1'b0});
        vq.push_back('{"sh_16",       1'b0, 1'b1, F3_H,  32'h16, 32'h8001,     32'h0,        1'b0});
        vq.push_back('{"lh_16",       1'b1, 1'b0, F3_H,  32'h16, 32'h0,        32'hFFFF8001, 1'b0});
        vq.push_back('{"lhu_16",      1'b1, 1'b0, F3_HU, 32'h16, 32'h0,        32'h00008001, 1'b0});
        vq.push_back('{"lw_14_merge", 1'b1, 1'b0, F3_W,  32'h14, 32'h0,        32'h8001BEEF, 1'b0});
        vq.push_back('{"sb_19",       1'b0, 1'b1, F3_B,  32'h19, 32'hFFFFFF5A, 32'h0,        1'b0});
        vq.push_back('{"lw_18",       1'b1, 1'b0, F3_W,  32'h18, 32'h0,        32'hA0005A02, 1'b0});
        vq.push_back('{"lb_18",       1'b1, 1'b0, F3_B,  32'h18, 32'h0,        32'h00000002, 1'b0});
        vq.push_back('{"lw_1b_unal",  1'b1, 1'b0, F3_W,  32'h1B, 32'h0,        32'hA0005A02, 1'b0});
        vq.push_back('{"rdwr_1c",     1'b1, 1'b1, F3_W,  32'h1C, 32'h12345678, 32'h0,        1'b0});
        vq.push_back('{"lw_1c",       1'b1, 1'b0, F3_W,  32'h1C, 32'h0,        32'h12345678, 1'b0});
        vq.push_back('{"no_req",      1'b0, 1'b0, F3_W,  32'h14, 32'h0,        32'h0,        1'b0});
        vq.push_back('{"lh_10",       1'b1, 1'b0, F3_H,  32'h10, 32'h0,        32'h00000100, 1'b0});
        vq.push_back('{"lb_13",       1'b1, 1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFA0, 1'b0});

        // Reset with a request already pending: outputs must stay low.
        RESET = 1'b0;
        drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        #12;
        chk("rst_busywait", 128'(busywait), 128'h0);
        chk("rst_readdata", 128'(readdata), 128'h0);
        chk("rst_mem_rw",   128'({mif.mem_Read, mif.mem_Write}), 128'h0);
        @(negedge CLK);
        RESET = 1'b1;
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);

        // Cold load miss: IDLE, 3 FETCH cycles, UPDATE, then hit.
        @(negedge CLK);
        drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        #2;
        wait_miss(n, saw_wb, wba, wbd, rda, ov);
        chk("cold_busy_cycles", 128'(n), 128'd5);
        chk("cold_no_wb",       128'(saw_wb), 128'h0);
        chk("cold_fetch_addr",  128'(rda), 128'h1);
        chk("cold_rw_overlap",  128'(ov), 128'h0);
        chk("cold_readdata",    128'(readdata), 128'hA0000100);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            drive(vq[i].rd, vq[i].wr, vq[i].f3, vq[i].addr, vq[i].wdata);
            #2;
            chk({vq[i].nm, "_rd"},   128'(readdata), 128'(vq[i].exp_rd));
            chk({vq[i].nm, "_busy"}, 128'(busywait), 128'(vq[i].exp_busy));
            chk({vq[i].nm, "_mem"},  128'({mif.mem_Read, mif.mem_Write}), 128'h0);
        end

        // Conflicting tag on dirty idx1 forces writeback of the modified block.
        exp_blk1 = {32'h12345678, 32'hA0005A02, 32'h8001BEEF, 32'hA0000100};
        @(negedge CLK);
        drive(1'b1, 1'b0, F3_W, 32'h90, 32'h0);
        #2;
        wait_miss(n, saw_wb, wba, wbd, rda, ov);
        chk("dirty_busy_cycles", 128'(n), 128'd8);
        chk("dirty_saw_wb",      128'(saw_wb), 128'h1);
        chk("dirty_wb_addr",     128'(wba), 128'h1);
        chk("dirty_wb_data",     wbd, exp_blk1);
        chk("dirty_fetch_addr",  128'(rda), 128'h9);
        chk("dirty_rw_overlap",  128'(ov), 128'h0);
        chk("dirty_readdata",    128'(readdata), 128'hA0000900);
        chk("dirty_mem_block1",  mem_wv[1] ? mem_wr[1] : 128'h0, exp_blk1);

        // Reset asserted mid-FETCH aborts the miss and clears valid bits.
        @(negedge CLK);
        drive(1'b1, 1'b0, F3_W, 32'h10, 32'h0);
        #2;
        chk("abort_miss_busy", 128'(busywait), 128'h1);
        @(negedge CLK); #2;
        chk("abort_in_fetch",  128'({mif.mem_Read, mif.mem_Address}), {99'h0, 1'b1, 28'h1});
        #1 RESET = 1'b0;
        #1;
        chk("abort_busywait",  128'(busywait), 128'h0);
        chk("abort_readdata",  128'(readdata), 128'h0);
        chk("abort_mem_rw",    128'({mif.mem_Read, mif.mem_Write}), 128'h0);
        chk("abort_mem_addr",  128'(mif.mem_Address), 128'h0);
        chk("abort_mem_wdata", mif.mem_Writedata, 128'h0);
        @(negedge CLK);
        RESET = 1'b1;
        drive(1'b1, 1'b0, F3_W, 32'h90, 32'h0);
        #2;
        chk("post_rst_miss", 128'(busywait), 128'h1);
        wait_miss(n, saw_wb, wba, wbd, rda, ov);
        chk("post_rst_busy_cycles", 128'(n), 128'd5);
        chk("post_rst_no_wb",       128'(saw_wb), 128'h0);
        chk("post_rst_readdata",    128'(readdata), 128'hA0000900);

        @(negedge CLK);
        drive(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
